crc_check: RTL and testbench

- Receive-side CRC checker/stripper for the USB serial bit path.
- Sits after NRZI decode and bit unstuffing, and before the packet field decoder.
- Runs CRC5 or CRC16 over each incoming packet body plus its trailing CRC bits and checks the result against the fixed residual.
- Forwards only the payload bits downstream (the trailing CRC bits are stripped) and reports pass/fail one cycle after the packet ends.

---
 rtl/crc_check.sv | 159 +++++++++++++++
 tb/tb_crc_check.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/crc_check.sv
// Receive-side USB CRC checker/stripper: runs CRC5 or CRC16 over the packet body
// plus its CRC field, forwards only the payload and pulses pass/fail after the packet.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for recving; CRC preset to ones, width select tracked
// RECV  | packet body; bits go into the CRC and the W-deep strip line
// DONE  | one cycle; result pulse is high, buffered CRC field is dropped
module crc_check #(
  parameter int MAXW    = 16,
  parameter int MINBITS = 1
) (
  input  logic clk,
  input  logic rst_L,
  input  logic inb,
  input  logic in_valid,
  input  logic recving,
  input  logic crc16_sel,
  output logic outb,
  output logic out_valid,
  output logic sending,
  output logic crc_ok,
  output logic crc_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] POLY16  = 16'h8005;
  localparam logic [4:0]  POLY5   = 5'b00101;
  localparam logic [15:0] RESID16 = 16'h800D;
  localparam logic [4:0]  RESID5  = 5'b01100;
  localparam logic [10:0] MIN16   = 11'(16 + MINBITS);
  localparam logic [10:0] MIN5    = 11'(5 + MINBITS);

  state_t          state_q, state_d;
  logic [MAXW-1:0] crc_q, crc_d;
  logic [MAXW-1:0] buf_q, buf_d;
  logic [10:0]     cnt_q, cnt_d;
  logic            sel_q, sel_d;
  logic            sending_q, sending_d;
  logic            ok_q, ok_d;
  logic            err_q, err_d;

  logic            fwd;
  logic            resid_hit;
  logic            long_enough;

  // Only the low W bits of the CRC register are meaningful; the rest are kept zero.
  function automatic logic [MAXW-1:0] crc_next(input logic [MAXW-1:0] c,
                                               input logic b, input logic s);
    logic [MAXW-1:0] r;
    logic            fb;
    r = '0;
    if (s) begin
      fb       = c[15] ^ b;
      r[15:0]  = {c[14:0], 1'b0} ^ (fb ? POLY16 : 16'h0000);
    end else begin
      fb       = c[4] ^ b;
      r[4:0]   = {c[3:0], 1'b0} ^ (fb ? POLY5 : 5'b00000);
    end
    return r;
  endfunction

  function automatic logic [MAXW-1:0] crc_preset(input logic s);
    logic [MAXW-1:0] r;
    r = '0;
    if (s) r[15:0] = '1;
    else   r[4:0]  = '1;
    return r;
  endfunction

  // A bit leaves the strip line only once W bits are already held behind it.
  assign fwd       = (state_q == RECV) && recving && in_valid &&
                     (cnt_q >= (sel_q ? 11'd16 : 11'd5));
  assign out_valid = fwd;
  assign outb      = fwd & (sel_q ? buf_q[15] : buf_q[4]);
  assign sending   = sending_q;
  assign crc_ok    = ok_q;
  assign crc_err   = err_q;

  assign resid_hit   = sel_q ? (crc_q[15:0] == RESID16) : (crc_q[4:0] == RESID5);
  assign long_enough = cnt_q >= (sel_q ? MIN16 : MIN5);

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    sending_d = 1'b0;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        sel_d = crc16_sel;
        crc_d = crc_preset(crc16_sel);
        buf_d = '0;
        cnt_d = '0;
        if (recving) begin
          state_d   = RECV;
          sending_d = 1'b1;
          if (in_valid) begin
            crc_d = crc_next(crc_preset(crc16_sel), inb, crc16_sel);
            buf_d = {{(MAXW-1){1'b0}}, inb};
            cnt_d = 11'd1;
          end
        end
      end
      RECV: begin
        if (!recving) begin
          state_d = DONE;
          ok_d    = resid_hit && long_enough;
          err_d   = !(resid_hit && long_enough);
        end else begin
          sending_d = 1'b1;
          if (in_valid) begin
            crc_d = crc_next(crc_q, inb, sel_q);
            buf_d = {buf_q[MAXW-2:0], inb};
            cnt_d = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        buf_d   = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q   <= IDLE;
      crc_q     <= '1;
      buf_q     <= '0;
      cnt_q     <= '0;
      sel_q     <= 1'b0;
      sending_q <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      sending_q <= sending_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_crc_check.sv
// Bench for crc_check: table of packets with a bit-serial CRC model building the
// CRC field, plus scoreboard queues for forwarded bits and result pulses.
module tb_crc_check;

  logic clk = 1'b0;
  logic rst_L = 1'b0;
  logic inb = 1'b0;
  logic in_valid = 1'b0;
  logic recving = 1'b0;
  logic crc16_sel = 1'b0;
  logic outb, out_valid, sending, crc_ok, crc_err;

  crc_check #(.MAXW(16), .MINBITS(1)) dut (
    .clk(clk), .rst_L(rst_L), .inb(inb), .in_valid(in_valid), .recving(recving),
    .crc16_sel(crc16_sel), .outb(outb), .out_valid(out_valid), .sending(sending),
    .crc_ok(crc_ok), .crc_err(crc_err)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   ov_cnt = 0;
  logic exp_bits[$];
  logic exp_res[$];

  typedef struct {
    string       name;
    logic        sel;
    int          npay;
    logic [15:0] pay;
    int          flip;
    bit          stall;
    bit          exp_ok;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT produced output with nothing expected", name);
  endtask

  // Scoreboard side: compare whatever the DUT emits against the queues.
  always @(negedge clk) begin
    if (rst_L) begin
      if (out_valid) begin
        ov_cnt++;
        if (exp_bits.size() == 0) fail("unexpected_outb");
        else chk("outb", 32'(outb), 32'(exp_bits.pop_front()));
      end
      if (crc_ok && crc_err) begin
        chk("ok_err_exclusive", 32'(crc_ok & crc_err), 32'd0);
      end else if (crc_ok || crc_err) begin
        if (exp_res.size() == 0) fail("unexpected_result");
        else chk("crc_ok", 32'(crc_ok), 32'(exp_res.pop_front()));
      end
    end
  end

  function automatic logic [15:0] model_crc(input logic sel, input bit b[32], input int n);
    logic [15:0] c;
    logic        fb;
    c = sel ? 16'hFFFF : 16'h001F;
    for (int i = 0; i < n; i++) begin
      if (sel) begin
        fb = c[15] ^ b[i];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end else begin
        fb      = c[4] ^ b[i];
        c[4:0]  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
        c[15:5] = '0;
      end
    end
    return c;
  endfunction

  task automatic drive_bits(input bit pkt[32], input int n, input logic sel, input bit stall);
    int k;
    @(posedge clk); #1;
    crc16_sel = sel;
    recving   = 1'b1;
    in_valid  = 1'b1;
    inb       = pkt[0];
    for (int i = 1; i < n; i++) begin
      @(posedge clk); #1;
      crc16_sel = ~sel;
      if (stall) begin
        k = $urandom_range(0, 3);
        repeat (k) begin
          in_valid = 1'b0;
          inb      = 1'($urandom);
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      inb      = pkt[i];
      if (i == 2) begin
        @(negedge clk);
        chk("sending_mid", 32'(sending), 32'd1);
      end
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    recving   = 1'b0;
    inb       = 1'b0;
    crc16_sel = 1'b0;
  endtask

  task automatic wait_result(input string name);
    for (int t = 0; t < 10 && exp_res.size() != 0; t++) begin
      @(negedge clk); #1;
    end
    chk({name, "_result_seen"}, 32'(exp_res.size()), 32'd0);
    exp_res.delete();
    @(negedge clk);
    chk({name, "_pulse_width"}, 32'({crc_ok, crc_err}), 32'd0);
    chk({name, "_sending_idle"}, 32'(sending), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    bit          pkt[32];
    int          w;
    int          n;
    logic [15:0] c;
    w = v.sel ? 16 : 5;
    n = v.npay + w;
    for (int i = 0; i < 32; i++) pkt[i] = 1'b0;
    for (int i = 0; i < v.npay; i++) pkt[i] = v.pay[i];
    c = ~model_crc(v.sel, pkt, v.npay);
    for (int j = 0; j < w; j++) pkt[v.npay + j] = c[w - 1 - j];
    if (v.flip >= 0) pkt[v.flip] = ~pkt[v.flip];
    for (int i = 0; i < v.npay; i++) exp_bits.push_back(pkt[i]);
    exp_res.push_back(v.exp_ok);
    ov_cnt = 0;
    drive_bits(pkt, n, v.sel, v.stall);
    wait_result(v.name);
    chk({v.name, "_out_count"}, 32'(ov_cnt), 32'(v.npay));
    chk({v.name, "_bits_left"}, 32'(exp_bits.size()), 32'd0);
    exp_bits.delete();
  endtask

  initial begin
    vec_t vecs[10];
    bit   sp[32];
    vecs[0] = '{"crc5_good",      1'b0, 11, 16'h0000, -1, 1'b0, 1'b1};
    vecs[1] = '{"crc5_flip3",     1'b0, 11, 16'h0000,  3, 1'b0, 1'b0};
    vecs[2] = '{"crc16_good",     1'b1,  8, 16'h0000, -1, 1'b0, 1'b1};
    vecs[3] = '{"crc16_lastflip", 1'b1,  8, 16'h0000, 23, 1'b0, 1'b0};
    vecs[4] = '{"crc5_stall",     1'b0, 11, 16'h0000, -1, 1'b1, 1'b1};
    vecs[5] = '{"crc5_rand",      1'b0, 11, 16'h05A3, -1, 1'b0, 1'b1};
    vecs[6] = '{"crc16_rand",     1'b1, 16, 16'hC3A5, -1, 1'b1, 1'b1};
    vecs[7] = '{"crc5_min",       1'b0,  1, 16'h0001, -1, 1'b0, 1'b1};
    vecs[8] = '{"crc5_nopay",     1'b0,  0, 16'h0000, -1, 1'b0, 1'b0};
    vecs[9] = '{"crc16_flipmid",  1'b1, 12, 16'h0ABC,  5, 1'b0, 1'b0};

    #12;
    chk("reset_outputs", 32'({outb, out_valid, sending, crc_ok, crc_err}), 32'd0);
    #10 rst_L = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Too-short packet: nothing forwarded, error pulse.
    for (int i = 0; i < 32; i++) sp[i] = 1'b0;
    sp[0] = 1'b1; sp[2] = 1'b1; sp[3] = 1'b1;
    exp_res.push_back(1'b0);
    ov_cnt = 0;
    drive_bits(sp, 4, 1'b0, 1'b0);
    wait_result("short");
    chk("short_out_count", 32'(ov_cnt), 32'd0);

    // Reset after 7 bits of a good token: the first two payload bits are already out.
    for (int i = 0; i < 32; i++) sp[i] = 1'b0;
    exp_bits.push_back(1'b0);
    exp_bits.push_back(1'b0);
    ov_cnt = 0;
    @(posedge clk); #1;
    crc16_sel = 1'b0; recving = 1'b1; in_valid = 1'b1; inb = sp[0];
    for (int i = 1; i < 7; i++) begin
      @(posedge clk); #1;
      inb = sp[i];
    end
    @(negedge clk); #1;
    rst_L = 1'b0;
    #1;
    chk("midreset_outputs", 32'({outb, out_valid, sending, crc_ok, crc_err}), 32'd0);
    chk("midreset_fwd_count", 32'(ov_cnt), 32'd2);
    chk("midreset_bits_left", 32'(exp_bits.size()), 32'd0);
    exp_bits.delete();
    recving = 1'b0; in_valid = 1'b0; inb = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_L = 1'b1;
    run_vec(vecs[0]);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
